// File: rtl/sa_skew_buf.sv
// Double-buffered DIM x DIM tile store feeding a systolic array edge.
// Tiles drain as diagonally skewed lane beats, row-wise (A operand) or column-wise (B operand).
module sa_skew_buf #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  localparam int ROWBITS = $clog2(DIM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ROWBITS-1:0]             wr_row,
  input  logic [DIM-1:0][BITS_AB-1:0]    wr_data,
  input  logic                           wr_commit,
  input  logic                           wr_mode,
  output logic                           wr_ready,
  input  logic                           drain_start,
  input  logic                           drain_stall,
  output logic [DIM-1:0][BITS_AB-1:0]    out_data,
  output logic                           out_valid,
  output logic                           drain_done,
  output logic                           tile_ready,
  output logic                           err
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam int TBITS = $clog2(2*DIM-1);
  localparam logic [TBITS-1:0] T_LAST = TBITS'(2*DIM-2);

  logic [DIM-1:0][BITS_AB-1:0] mem [2][DIM];
  logic [1:0]                  full;
  logic [1:0]                  mode;
  logic                        load_ptr;
  logic                        drain_ptr;
  state_t                      state;
  state_t                      state_nxt;
  logic [TBITS-1:0]            t;
  logic [TBITS-1:0]            t_nxt;
  logic                        beat_bank;
  logic                        load_beat;
  logic                        clear_out;
  logic [DIM-1:0][BITS_AB-1:0] beat_nxt;
  logic                        finish;
  logic                        start_ok;

  assign wr_ready   = ~full[load_ptr];
  assign out_valid  = (state == DRAIN);
  assign drain_done = (state == DRAIN) && (t == T_LAST);
  assign tile_ready = (state == IDLE) && (|full);
  assign finish     = drain_done && !drain_stall;

  // A start is legal from IDLE, or on an unstalled last beat when the other bank is already waiting.
  assign start_ok = drain_start &&
                    (((state == IDLE) && full[drain_ptr]) || (finish && full[~drain_ptr]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem       <= '{default: '0};
      full      <= '0;
      mode      <= '0;
      load_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
    end else begin
      if (wr_en && wr_ready)
        mem[load_ptr][wr_row] <= wr_data;
      if (wr_commit && wr_ready) begin
        full[load_ptr] <= 1'b1;
        mode[load_ptr] <= wr_mode;
        load_ptr       <= ~load_ptr;
      end
      if (finish) begin
        full[drain_ptr] <= 1'b0;
        drain_ptr       <= ~drain_ptr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    beat_bank = drain_ptr;
    load_beat = 1'b0;
    clear_out = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = DRAIN;
          t_nxt     = '0;
          load_beat = 1'b1;
        end
      end
      DRAIN: begin
        if (!drain_stall) begin
          if (t != T_LAST) begin
            t_nxt     = t + 1'b1;
            load_beat = 1'b1;
          end else if (start_ok) begin
            t_nxt     = '0;
            beat_bank = ~drain_ptr;
            load_beat = 1'b1;
          end else begin
            state_nxt = IDLE;
            t_nxt     = '0;
            clear_out = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
        clear_out = 1'b1;
      end
    endcase
  end

  // Lane j is delayed by j beats; lanes outside the tile diagonal band carry zero.
  always_comb begin : beat_mux
    int k;
    k        = 0;
    beat_nxt = '0;
    for (int j = 0; j < DIM; j++) begin
      k = int'(t_nxt) - j;
      if (k >= 0 && k < DIM) begin
        if (mode[beat_bank])
          beat_nxt[ROWBITS'(j)] = mem[beat_bank][ROWBITS'(k)][ROWBITS'(j)];
        else
          beat_nxt[ROWBITS'(j)] = mem[beat_bank][ROWBITS'(j)][ROWBITS'(k)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      if (load_beat)
        out_data <= beat_nxt;
      else if (clear_out)
        out_data <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (((wr_en || wr_commit) && !wr_ready) || (drain_start && !start_ok))
      err <= 1'b1;
  end

endmodule

// File: tb/tb_sa_skew_buf.sv
// Self-checking bench for sa_skew_buf: directed tile drains plus random traffic,
// compared every cycle against a bank-level behavioural model.
module tb_sa_skew_buf;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int LAST    = 2*DIM-2;

  logic                        clk;
  logic                        rst;
  logic                        wr_en;
  logic [2:0]                  wr_row;
  logic [DIM-1:0][BITS_AB-1:0] wr_data;
  logic                        wr_commit;
  logic                        wr_mode;
  logic                        wr_ready;
  logic                        drain_start;
  logic                        drain_stall;
  logic [DIM-1:0][BITS_AB-1:0] out_data;
  logic                        out_valid;
  logic                        drain_done;
  logic                        tile_ready;
  logic                        err;

  sa_skew_buf #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_mode(wr_mode), .wr_ready(wr_ready),
    .drain_start(drain_start), .drain_stall(drain_stall),
    .out_data(out_data), .out_valid(out_valid), .drain_done(drain_done),
    .tile_ready(tile_ready), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  logic [63:0] beat_q[$];
  bit          done_q[$];
  int          cyc_q[$];
  logic [63:0] row_beats[15];

  // Model: two physical banks with FULL tags, FIFO drain order, beat index t.
  logic [7:0] mbank[2][8][8];
  bit mfull[2];
  bit mmode[2];
  bit mlp, mdp, mdrain, merr;
  int mt;

  function automatic void modelReset();
    for (int b = 0; b < 2; b++) begin
      mfull[b] = 0;
      mmode[b] = 0;
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < 8; k++) mbank[b][i][k] = 8'h00;
    end
    mlp = 0; mdp = 0; mdrain = 0; merr = 0; mt = 0;
  endfunction

  function automatic logic [63:0] modelBeat();
    logic [63:0] r;
    int k;
    r = '0;
    if (mdrain) begin
      for (int j = 0; j < DIM; j++) begin
        k = mt - j;
        if (k >= 0 && k < DIM)
          r[j*8 +: 8] = mmode[mdp] ? mbank[mdp][k][j] : mbank[mdp][j][k];
      end
    end
    return r;
  endfunction

  function automatic void modelStep();
    bit wrdy, fin, sok, odp;
    if (rst) return;
    wrdy = !mfull[mlp];
    fin  = mdrain && (mt == LAST) && !drain_stall;
    sok  = drain_start && ((!mdrain && mfull[mdp]) || (fin && mfull[!mdp]));
    if ((wr_en || wr_commit) && !wrdy) merr = 1;
    if (drain_start && !sok) merr = 1;
    odp = mdp;
    if (wrdy && wr_en)
      for (int k = 0; k < 8; k++) mbank[mlp][wr_row][k] = wr_data[k];
    if (wrdy && wr_commit) begin
      mfull[mlp] = 1;
      mmode[mlp] = wr_mode;
      mlp = !mlp;
    end
    if (!mdrain) begin
      if (sok) begin
        mdrain = 1;
        mt = 0;
      end
    end else if (!drain_stall) begin
      if (mt < LAST) mt++;
      else begin
        mfull[odp] = 0;
        mdp = !mdp;
        if (sok) mt = 0;
        else mdrain = 0;
      end
    end
  endfunction

  function automatic logic [7:0] tileVal(int kind, int i, int k);
    if (kind == 0) return 8'(8*i + k);
    return 8'(16*i + k + 3);
  endfunction

  function automatic logic [63:0] rowBeat7();
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = 8'(7*j + 7);
    return r;
  endfunction

  function automatic logic [63:0] colBeat7();
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = 8'(56 - 7*j);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        checkOutput("out_valid",  out_valid,  mdrain);
        checkOutput("out_data",   out_data,   modelBeat());
        checkOutput("drain_done", drain_done, mdrain && (mt == LAST));
        checkOutput("wr_ready",   wr_ready,   !mfull[mlp]);
        checkOutput("tile_ready", tile_ready, !mdrain && (mfull[0] || mfull[1]));
        checkOutput("err",        err,        merr);
        if (out_valid) begin
          beat_q.push_back(out_data);
          done_q.push_back(drain_done);
          cyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input bit we, input int row, input logic [63:0] data,
                               input bit commit, input bit mode, input bit ds, input bit stall);
    wr_en       = we;
    wr_row      = row[2:0];
    wr_data     = data;
    wr_commit   = commit;
    wr_mode     = mode;
    drain_start = ds;
    drain_stall = stall;
    tick();
  endtask

  task automatic idle();
    applyStimulus(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic loadTile(input int kind, input bit mode);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) d[k*8 +: 8] = tileVal(kind, i, k);
      applyStimulus(1, i, d, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, '0, 1, mode, 0, 0);
  endtask

  task automatic waitDrainEnd();
    int n;
    n = 0;
    while (mdrain && n < 100) begin
      idle();
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: still draining after %0d cycles, required idle", n);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clearBeats();
    beat_q.delete();
    done_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    int s, n;
    bit started;
    wr_en = 0; wr_row = 0; wr_data = '0; wr_commit = 0; wr_mode = 0;
    drain_start = 0; drain_stall = 0;
    rst = 1'b1;
    modelReset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_ready",   wr_ready,   1);
    checkOutput("rst_out_valid",  out_valid,  0);
    checkOutput("rst_tile_ready", tile_ready, 0);
    checkOutput("rst_err",        err,        0);
    rst = 1'b0;

    // ROW drain of tile 8*i+k
    loadTile(0, 0);
    clearBeats();
    applyStimulus(0, 0, '0, 0, 0, 1, 0);
    waitDrainEnd();
    checkOutput("row_beat_count", beat_q.size(), 15);
    if (beat_q.size() == 15) begin
      for (int b = 0; b < 15; b++) row_beats[b] = beat_q[b];
      checkOutput("row_beat0",  beat_q[0],  64'h0);
      checkOutput("row_beat7",  beat_q[7],  rowBeat7());
      checkOutput("row_beat14", beat_q[14], 64'h3F00_0000_0000_0000);
      checkOutput("row_done14", done_q[14], 1);
      checkOutput("row_done13", done_q[13], 0);
    end

    // COL drain of the same tile
    loadTile(0, 1);
    clearBeats();
    applyStimulus(0, 0, '0, 0, 0, 1, 0);
    waitDrainEnd();
    checkOutput("col_beat_count", beat_q.size(), 15);
    if (beat_q.size() == 15) begin
      checkOutput("col_beat7",  beat_q[7],  colBeat7());
      checkOutput("col_beat14", beat_q[14], 64'h3F00_0000_0000_0000);
    end

    // Ping-pong: Y loaded during X drain, chained on drain_done
    loadTile(0, 0);
    clearBeats();
    applyStimulus(0, 0, '0, 0, 0, 1, 0);
    loadTile(1, 1);
    started = 0;
    n = 0;
    while (!started && n < 40) begin
      if (mdrain && mt == LAST) begin
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        started = 1;
      end else idle();
      n++;
    end
    waitDrainEnd();
    checkOutput("pp_beat_count", beat_q.size(), 30);
    if (beat_q.size() == 30) begin
      checkOutput("pp_contiguous", cyc_q[29] - cyc_q[0], 29);
      checkOutput("pp_x_beat7",    beat_q[7], rowBeat7());
      checkOutput("pp_x_done",     done_q[14], 1);
      checkOutput("pp_y_beat0",    beat_q[15], 64'h03);
      checkOutput("pp_y_beat14",   beat_q[29], {8'd122, 56'h0});
      checkOutput("pp_y_done",     done_q[29], 1);
    end

    // Stall for 3 cycles at t=4
    loadTile(0, 0);
    clearBeats();
    applyStimulus(0, 0, '0, 0, 0, 1, 0);
    s = 0;
    n = 0;
    while (mdrain && n < 100) begin
      if (mt == 4 && s < 3) begin
        applyStimulus(0, 0, '0, 0, 0, 0, 1);
        s++;
      end else idle();
      n++;
    end
    checkOutput("stall_beat_count", beat_q.size(), 18);
    if (beat_q.size() == 18) begin
      for (int b = 0; b < 18; b++)
        checkOutput("stall_beat", beat_q[b], row_beats[(b < 5) ? b : (b < 8 ? 4 : b - 3)]);
    end

    // Write with both banks full is dropped
    doReset();
    loadTile(0, 0);
    loadTile(1, 1);
    applyStimulus(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
    checkOutput("full_write_err",   err,      1);
    checkOutput("full_wr_ready",    wr_ready, 0);
    clearBeats();
    applyStimulus(0, 0, '0, 0, 0, 1, 0);
    waitDrainEnd();
    if (beat_q.size() >= 8) begin
      checkOutput("full_bank_beat0", beat_q[0], 64'h0);
      checkOutput("full_bank_beat7", beat_q[7], rowBeat7());
    end else checkOutput("full_bank_beats", beat_q.size(), 15);

    // drain_start with nothing to drain
    doReset();
    applyStimulus(0, 0, '0, 0, 0, 1, 0);
    checkOutput("empty_start_valid", out_valid, 0);
    checkOutput("empty_start_err",   err,       1);

    // Reset in the middle of a drain
    doReset();
    loadTile(0, 0);
    applyStimulus(0, 0, '0, 0, 0, 1, 0);
    repeat (5) idle();
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    checkOutput("mid_rst_valid",      out_valid,  0);
    checkOutput("mid_rst_data",       out_data,   64'h0);
    checkOutput("mid_rst_done",       drain_done, 0);
    checkOutput("mid_rst_wr_ready",   wr_ready,   1);
    checkOutput("mid_rst_tile_ready", tile_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearBeats();
    repeat (20) idle();
    checkOutput("mid_rst_no_residue", beat_q.size(), 0);
    checkOutput("mid_rst_wr_ready_after", wr_ready, 1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) doReset();
      else
        applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 7), {$urandom, $urandom},
                      $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 11) == 0) || (mdrain && mt == LAST && $urandom_range(0, 1) == 1),
                      $urandom_range(0, 4) == 0);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
